// File: rtl/nbit_serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: default width and FSM state encoding.
package nbit_serial_sub_pkg;

  localparam int DEFAULT_SIZE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nbit_serial_sub_fs.sv
// Single-bit full subtractor: d = a - b - bi, bo = borrow out.
module nbit_serial_sub_fs (
  input  logic a_i,
  input  logic b_i,
  input  logic bi_i,
  output logic d_o,
  output logic bo_o
);

  assign d_o  = a_i ^ b_i ^ bi_i;
  assign bo_o = (~a_i & b_i) | (~a_i & bi_i) | (b_i & bi_i);

endmodule

// File: rtl/nbit_serial_sub.sv
// Bit-serial subtractor: processes one bit per cycle through a single full subtractor.
// state | meaning
// IDLE  | ready, waiting for start; result registers hold the last answer
// RUN   | one bit per cycle, LSB first
// DONE  | one-cycle result-valid pulse
module nbit_serial_sub
  import nbit_serial_sub_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            bi,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] d,
  output logic [SIZE:0]   bo
);

  localparam int IW = $clog2(SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

  state_e            state_q, state_d;
  logic [SIZE-1:0]   a_q, a_d;
  logic [SIZE-1:0]   b_q, b_d;
  logic [SIZE-1:0]   diff_q, diff_d;
  logic [SIZE:0]     borrow_q, borrow_d;
  logic [IW-1:0]     idx_q, idx_d;

  logic [SIZE-1:0]   borrow_in_vec;
  logic              fs_d, fs_bo;

  // Borrow into bit k lives at borrow_q[k]; the low slice keeps the index width exact.
  assign borrow_in_vec = borrow_q[SIZE-1:0];

  nbit_serial_sub_fs fs (
    .a_i  (a_q[idx_q]),
    .b_i  (b_q[idx_q]),
    .bi_i (borrow_in_vec[idx_q]),
    .d_o  (fs_d),
    .bo_o (fs_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (idx_q == LAST_IDX) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    idx_d    = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          diff_d   = '0;
          borrow_d = {{SIZE{1'b0}}, bi};
          idx_d    = '0;
        end
      end
      ST_RUN: begin
        for (int k = 0; k < SIZE; k++) begin
          if (idx_q == IW'(k)) begin
            diff_d[k]     = fs_d;
            borrow_d[k+1] = fs_bo;
          end
        end
        // Index parks on the last bit rather than wrapping.
        if (idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ready = (state_q == ST_IDLE);
    busy  = (state_q == ST_RUN);
    done  = (state_q == ST_DONE);
  end

  assign d  = diff_q;
  assign bo = borrow_q;

endmodule

// File: tb/tb_nbit_serial_sub.sv
// Directed and randomised checks of nbit_serial_sub at SIZE=4 and SIZE=8.
module tb_nbit_serial_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       s4, bi4, r4, bz4, dn4;
  logic [3:0] a4, b4, d4;
  logic [4:0] bo4;

  logic       s8, bi8, r8, bz8, dn8;
  logic [7:0] a8, b8, d8;
  logic [8:0] bo8;

  int n_pass = 0;
  int n_chk  = 0;
  int lat;
  int ndone;
  logic [8:0] ref9;

  nbit_serial_sub #(.SIZE(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .bi(bi4),
    .ready(r4), .busy(bz4), .done(dn4), .d(d4), .bo(bo4)
  );

  nbit_serial_sub #(.SIZE(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .bi(bi8),
    .ready(r8), .busy(bz8), .done(dn8), .d(d8), .bo(bo8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Pulses start for one cycle, returns at the negedge where done is seen (lat counts cycles).
  task automatic go4(input logic [3:0] av, input logic [3:0] bv, input logic biv, output int l);
    @(negedge clk);
    a4 = av; b4 = bv; bi4 = biv; s4 = 1'b1;
    l = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      s4 = 1'b0;
      if (dn4) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic go8(input logic [7:0] av, input logic [7:0] bv, input logic biv, output int l);
    @(negedge clk);
    a8 = av; b8 = bv; bi8 = biv; s8 = 1'b1;
    l = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      s8 = 1'b0;
      if (dn8) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s4 = 0; a4 = 0; b4 = 0; bi4 = 0;
    s8 = 0; a8 = 0; b8 = 0; bi8 = 0;
    #12;
    chk("rst_ready", 32'(r4), 32'd1);
    chk("rst_busy",  32'(bz4), 32'd0);
    chk("rst_done",  32'(dn4), 32'd0);
    chk("rst_d",     32'(d4), 32'd0);
    chk("rst_bo",    32'(bo4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 9 - 3
    go4(4'd9, 4'd3, 1'b0, lat);
    chk("lat_9_3",   32'(lat), 32'd5);
    chk("d_9_3",     32'(d4), 32'h6);
    chk("bo_9_3",    32'(bo4), 32'b01100);
    chk("ready_in_done", 32'(r4), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(dn4), 32'd0);
    chk("ready_after", 32'(r4), 32'd1);
    a4 = 4'hF; b4 = 4'h1; bi4 = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_d",  32'(d4), 32'h6);
    chk("hold_bo", 32'(bo4), 32'b01100);

    // 3 - 9 wraps
    go4(4'd3, 4'd9, 1'b0, lat);
    chk("lat_3_9", 32'(lat), 32'd5);
    chk("d_3_9",   32'(d4), 32'hA);
    chk("bo4_3_9", 32'(bo4[4]), 32'd1);

    // 0 - 0 - 1
    go4(4'd0, 4'd0, 1'b1, lat);
    chk("d_0_0_1",  32'(d4), 32'hF);
    chk("bo_0_0_1", 32'(bo4), 32'b11111);
    @(negedge clk);

    // start held during RUN must be ignored
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd3; bi4 = 1'b0; s4 = 1'b1;
    @(negedge clk);
    a4 = 4'd1; b4 = 4'd1; bi4 = 1'b1;
    chk("busy_run", 32'(bz4), 32'd1);
    ndone = 0;
    for (int k = 2; k <= 14; k++) begin
      @(negedge clk);
      if (k == 4) s4 = 1'b0;
      if (dn4) ndone++;
    end
    chk("single_done", 32'(ndone), 32'd1);
    chk("d_ignore",    32'(d4), 32'h6);
    chk("ready_ignore", 32'(r4), 32'd1);

    // reset in the second RUN cycle aborts
    @(negedge clk);
    a4 = 4'd0; b4 = 4'd0; bi4 = 1'b1; s4 = 1'b1;
    @(negedge clk);
    s4 = 1'b0;
    @(negedge clk);
    chk("busy_pre_rst", 32'(bz4), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(r4), 32'd1);
    chk("abort_busy",  32'(bz4), 32'd0);
    chk("abort_d",     32'(d4), 32'd0);
    chk("abort_bo",    32'(bo4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (dn4) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    go4(4'd5, 4'd2, 1'b0, lat);
    chk("lat_5_2", 32'(lat), 32'd5);
    chk("d_5_2",   32'(d4), 32'h3);
    chk("bo4_5_2", 32'(bo4[4]), 32'd0);
    @(negedge clk);

    // SIZE=8 randomised against a 9-bit arithmetic reference
    for (int n = 0; n < 1000; n++) begin
      logic [7:0] ra, rb;
      logic       rbi;
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rbi = 1'($urandom_range(0, 1));
      ref9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
      go8(ra, rb, rbi, lat);
      if (n == 0) chk("lat8", 32'(lat), 32'd9);
      if (lat < 0) begin
        chk("timeout8", 32'(lat), 32'd9);
        break;
      end
      chk("d8",  32'(d8), 32'(ref9[7:0]));
      chk("bo8", 32'(bo8[8]), 32'(ref9[8]));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/nbit_serial_sub.md
NBIT_SERIAL_SUB -- requirements
Module: nbit_serial_sub

Interface
REQ-001 The block SHALL have the parameter: SIZE, default 4, operand width in bits (SIZE >= 2).
REQ-002 The block SHALL have the port: clk  input  1  single clock, all state on rising edge.
REQ-003 The block SHALL have the port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have the port: start  input  1  request to begin a subtraction.
REQ-005 The block SHALL have the port: a  input  SIZE  minuend.
REQ-006 The block SHALL have the port: b  input  SIZE  subtrahend.
REQ-007 The block SHALL have the port: bi  input  1  borrow-in.
REQ-008 The block SHALL have the port: ready  output  1  high when idle and able to accept start.
REQ-009 The block SHALL have the port: busy  output  1  high while bits are being processed.
REQ-010 The block SHALL have the port: done  output  1  one-cycle pulse when the result is valid.
REQ-011 The block SHALL have the port: d  output  SIZE  difference a - b - bi.
REQ-012 The block SHALL have the port: bo  output  SIZE+1  borrow chain; bo[0]=bi, bo[i+1]=borrow out of bit i, bo[SIZE]=final borrow.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, DONE; ready=1 only in IDLE, busy=1 only in RUN, done=1 only in DONE.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL capture a, b, bi into internal registers, clear d and bo[SIZE:1], set bo[0]=bi, clear the bit index to 0, and enter RUN.
REQ-015 In RUN, each cycle the block SHALL process bit k=index: d[k] = a[k]^b[k]^bo[k]; bo[k+1] = (~a[k]&b[k]) | (~a[k]&bo[k]) | (b[k]&bo[k]); then increment the index.
REQ-016 After processing bit SIZE-1, the block SHALL enter DONE; DONE SHALL last exactly one cycle, then return to IDLE.
REQ-017 Latency: with start sampled at edge T, done SHALL be high in the cycle after edge T+SIZE (SIZE RUN cycles plus one DONE cycle); throughput is one operation per SIZE+2 cycles.
REQ-018 The block SHALL hold d and bo stable from DONE until the next accepted start.
REQ-019 The block SHALL ignore start in RUN and DONE; the operands captured at acceptance SHALL be unaffected by later changes on a, b, bi.
REQ-020 The block SHALL compute the result modulo 2^SIZE, with bo[SIZE]=1 iff a < b + bi as unsigned values.
REQ-021 The bit index SHALL be ceil(log2(SIZE)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-022 On rst_n=0, the block SHALL immediately enter IDLE and force ready=1, busy=0, done=0, d=0, bo=0, index=0, and clear the operand registers.
REQ-023 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after release SHALL begin a fresh operation.

Structure
REQ-024 The FSM state encoding (IDLE, RUN, DONE) SHALL be defined as shared constants in the block's common package/include, alongside the default SIZE.
REQ-025 The block SHALL implement the per-bit logic as one combinational sub-module, fs (full subtractor: a, b, bi -> d, bo), instantiated once and fed the indexed bit.

Verification
REQ-026 The bench SHALL cover: SIZE=4, a=9, b=3, bi=0, start pulse -> done after 5 cycles, d=4'h6, bo=5'b01100.
REQ-027 The bench SHALL cover: SIZE=4, a=3, b=9, bi=0 -> d=4'hA, bo[4]=1.
REQ-028 The bench SHALL cover: SIZE=4, a=0, b=0, bi=1 -> d=4'hF, bo=5'b11111.
REQ-029 The bench SHALL cover: start with a=9, b=3, then start=1 with a=1, b=1 during RUN -> single done, d=4'h6, no second operation begins.
REQ-030 The bench SHALL cover: rst_n=0 during the 2nd RUN cycle -> ready=1, d=0, bo=0, no done pulse; a subsequent start with a=5, b=2 -> d=4'h3, bo[4]=0.
REQ-031 The bench SHALL cover: SIZE=8, random a, b, bi (>=1000 operations) -> d and bo[SIZE] match the reference model (a-b-bi) mod 256 and borrow in every case.
